// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: decodes the PicoSoC iomem request to one slave slot, waits for its ready or a timeout,
// and returns one registered response. Define IOMEM_ERR_CAPTURE_EN to record timed-out addresses and counts.
module iomem_bus_ctrl #(
    parameter int                    NUM_SLAVES     = 8,
    parameter logic [7:0]            SEL_BASE       = 8'h03,
    parameter logic [NUM_SLAVES-1:0] SLAVE_PRESENT  = {NUM_SLAVES{1'b1}},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     busy,
    output logic                     timeout_pulse,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count,
    input  logic                     err_clear
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [15:0]             count;
    logic [7:0]              idx;
    logic [NUM_SLAVES-1:0]   sel;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    timeout_hit;
    logic                    abort;

    // Out-of-range and unpopulated slots both decode to an all-zero select, i.e. a miss.
    assign idx = m_addr[31:24] - SEL_BASE;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = (idx == 8'(i)) && SLAVE_PRESENT[i];
        end
    end

    // s_valid is the latched one-hot slot, so it masks both ready and read data.
    assign sel_ready = |(s_ready & s_valid);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_valid[i]) begin
                sel_rdata = sel_rdata | s_rdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (count == TO_LAST);
    assign abort       = (state == ACCESS) && !sel_ready && timeout_hit;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            m_ready       <= 1'b0;
            m_rdata       <= '0;
            s_valid       <= '0;
            s_addr        <= '0;
            s_wdata       <= '0;
            s_wstrb       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            m_ready       <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid && !m_ready) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        count   <= '0;
                        if (|sel) begin
                            s_valid <= sel;
                            state   <= ACCESS;
                        end else begin
                            m_rdata <= '0;
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    count <= count + 16'd1;
                    if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state   <= RESP;
                    end else if (timeout_hit) begin
                        m_rdata       <= TIMEOUT_RDATA;
                        s_valid       <= '0;
                        m_ready       <= 1'b1;
                        timeout_pulse <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IOMEM_ERR_CAPTURE_EN
    // A timeout on the same edge as err_clear counts as the first error after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr  <= '0;
            err_count <= '0;
        end else if (abort) begin
            err_addr  <= s_addr;
            err_count <= err_clear ? 8'd1 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
        end else if (err_clear) begin
            err_addr  <= '0;
            err_count <= '0;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_clear | abort;
    assign err_addr   = '0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Self-checking bench for iomem_bus_ctrl: transaction-level model with closed-form timing per request.
`timescale 1ns/1ps
module tb_iomem_bus_ctrl;

    localparam int          N     = 8;
    localparam int          T     = 16;
    localparam logic [31:0] TO_RD = 32'hDEAD_BEEF;
    localparam int          BIG   = 1000000;

    logic           clk = 1'b0;
    logic           reset, m_valid, m_ready, busy, timeout_pulse, err_clear;
    logic [3:0]     m_wstrb, s_wstrb;
    logic [31:0]    m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
    logic [N-1:0]   s_valid, s_ready;
    logic [32*N-1:0] s_rdata;
    logic [7:0]     err_count;

    logic           b_m_valid, b_m_ready, b_busy, b_timeout_pulse;
    logic [3:0]     b_m_wstrb, b_s_wstrb;
    logic [31:0]    b_m_addr, b_m_wdata, b_m_rdata, b_s_addr, b_s_wdata, b_err_addr;
    logic [N-1:0]   b_s_valid, b_s_ready;
    logic [32*N-1:0] b_s_rdata;
    logic [7:0]     b_err_count;

    always #5 clk = ~clk;

    iomem_bus_ctrl #(.NUM_SLAVES(N), .SEL_BASE(8'h03), .SLAVE_PRESENT(8'hFF),
                     .TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(TO_RD)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .s_valid(s_valid),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready),
        .s_rdata(s_rdata), .busy(busy), .timeout_pulse(timeout_pulse),
        .err_addr(err_addr), .err_count(err_count), .err_clear(err_clear));

    iomem_bus_ctrl #(.NUM_SLAVES(N), .SEL_BASE(8'h03), .SLAVE_PRESENT(8'hFE),
                     .TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(TO_RD)) dut_b (
        .clk(clk), .reset(reset), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_wstrb(b_m_wstrb),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata), .s_valid(b_s_valid),
        .s_wstrb(b_s_wstrb), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_ready(b_s_ready),
        .s_rdata(b_s_rdata), .busy(b_busy), .timeout_pulse(b_timeout_pulse),
        .err_addr(b_err_addr), .err_count(b_err_count), .err_clear(err_clear));

    // Model of the transaction in flight: off = cycles since the accepting edge (1 = first cycle after it).
    int          off, cur_slot, cur_len, err_cnt;
    bit          cur_hit, cur_to, chk_en, rand_clr;
    logic [31:0] cur_rd, cur_addr, cur_wdata, err_a;
    logic [3:0]  cur_wstrb;
    int          n_checks, n_errs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        off = BIG; cur_hit = 0; cur_to = 0; cur_slot = 0; cur_len = 0;
        cur_rd = '0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        err_cnt = 0; err_a = '0;
    endfunction

    always @(negedge clk) begin : cmp
        logic [7:0] esv;
        if (chk_en) begin
            esv = (cur_hit && off >= 1 && off <= cur_len - 1) ? 8'(1 << cur_slot) : 8'h00;
            chk("s_valid", 32'(s_valid), 32'(esv));
            chk("m_ready", 32'(m_ready), 32'(off == cur_len));
            chk("busy", 32'(busy), 32'(off >= 1 && off <= cur_len));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(cur_to && off == cur_len));
            if (off >= cur_len) chk("m_rdata", m_rdata, cur_rd);
            chk("s_addr", s_addr, cur_addr);
            chk("s_wdata", s_wdata, cur_wdata);
            chk("s_wstrb", 32'(s_wstrb), 32'(cur_wstrb));
`ifdef IOMEM_ERR_CAPTURE_EN
            chk("err_addr", err_addr, err_a);
            chk("err_count", 32'(err_count), 32'(err_cnt));
`else
            chk("err_addr", err_addr, 32'h0);
            chk("err_count", 32'(err_count), 32'h0);
`endif
        end
    end

    // Advance one clock and apply what the spec says happened on that edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (cur_to && off == cur_len - 1) begin
                err_cnt = err_clear ? 1 : ((err_cnt >= 255) ? 255 : err_cnt + 1);
                err_a   = cur_addr;
            end else if (err_clear) begin
                err_cnt = 0;
                err_a   = '0;
            end
            off++;
        end
        err_clear = rand_clr && ($urandom_range(0, 7) == 0);
        s_ready   = N'($urandom);
    endtask

    task automatic idle(input int n);
        m_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // d = ready delay: selected slave raises ready in ACCESS cycle d+1.
    task automatic run_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                           input int d, input bit drop, input int rst_at, input int clr_at,
                           input logic [31:0] rv, output int lat, output int svc, output int tos,
                           output logic [31:0] rds);
        logic [7:0]  ix;
        logic [7:0]  oh;
        bit          hit, to;
        int          len;
        ix  = a[31:24] - 8'h03;
        hit = (ix < 8);
        to  = hit && (d >= T);
        len = !hit ? 1 : (to ? T + 1 : d + 2);
        oh  = hit ? 8'(1 << ix) : 8'h00;
        m_valid = 1'b1; m_addr = a; m_wstrb = ws; m_wdata = wd;
        step();
        cur_hit = hit; cur_to = to; cur_slot = int'(ix); cur_len = len;
        cur_rd  = !hit ? 32'h0 : (to ? TO_RD : rv);
        cur_addr = a; cur_wdata = wd; cur_wstrb = ws; off = 1;
        lat = -1; svc = 0; tos = 0; rds = '0;
        for (int k = 1; k <= 4 * T; k++) begin
            s_ready = N'($urandom) & ~oh;
            for (int j = 0; j < N; j++) s_rdata[32*j +: 32] = $urandom;
            if (hit && k == d + 1) begin
                s_ready = s_ready | oh;
                s_rdata[32*int'(ix) +: 32] = rv;
            end
            if (drop) m_valid = ($urandom_range(0, 1) == 1);
            if (k == clr_at) err_clear = 1'b1;
            if (k == rst_at) begin reset = 1'b1; m_valid = 1'b0; end
            @(negedge clk);
            if (s_valid != '0) svc++;
            if (timeout_pulse) tos++;
            if (m_ready) begin lat = k; rds = m_rdata; end
            step();
            if (k == rst_at) begin reset = 1'b0; break; end
            if (lat >= 0) break;
        end
        if (lat < 0 && rst_at == 0) begin
            n_checks++; n_errs++;
            $display("FAIL txn_done: no m_ready for addr %08h within %0d cycles", a, 4 * T);
        end
        m_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        int lat, svc, tos;
        logic [31:0] rds, a;
        logic [7:0]  hi;
        int d;
        n_checks = 0; n_errs = 0; chk_en = 0; rand_clr = 0;
        reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0; err_clear = 1'b0;
        b_m_valid = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_m_wstrb = '0; b_s_ready = '0;
        b_s_rdata = '0; b_s_rdata[63:32] = 32'h5555_0001;
        model_reset();
        step(); step();
        reset = 1'b0;
        chk_en = 1;
        step();

        // Second instance: slot 0 unpopulated behaves as a miss, slot 1 still works.
        b_m_addr = 32'h0300_0000; b_m_valid = 1'b1;
        step(); b_m_valid = 1'b0;
        @(negedge clk);
        chk("b_miss_s_valid", 32'(b_s_valid), 32'h0);
        chk("b_miss_m_ready", 32'(b_m_ready), 32'h1);
        chk("b_miss_m_rdata", b_m_rdata, 32'h0);
        step();
        b_m_addr = 32'h0400_0000; b_m_valid = 1'b1; b_s_ready = '1;
        step(); b_m_valid = 1'b0;
        @(negedge clk);
        chk("b_hit_s_valid", 32'(b_s_valid), 32'h02);
        chk("b_hit_busy", 32'(b_busy), 32'h1);
        step();
        @(negedge clk);
        chk("b_hit_m_ready", 32'(b_m_ready), 32'h1);
        chk("b_hit_m_rdata", b_m_rdata, 32'h5555_0001);
        chk("b_hit_s_addr", b_s_addr, 32'h0400_0000);
        chk("b_timeout_pulse", 32'(b_timeout_pulse), 32'h0);
        chk("b_s_wstrb", 32'(b_s_wstrb), 32'h0);
        chk("b_s_wdata", b_s_wdata, 32'h0);
        chk("b_err_addr", b_err_addr, 32'h0);
        chk("b_err_count", 32'(b_err_count), 32'h0);
        step();

        run_txn(32'h0300_0010, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0000_00A5, lat, svc, tos, rds);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_svalid_cycles", 32'(svc), 32'd1);
        chk("t1_rdata", rds, 32'h0000_00A5);

        run_txn(32'h0700_0004, 4'hF, 32'h1234_5678, 4, 1, 0, 0, 32'h0BAD_0004, lat, svc, tos, rds);
        chk("t2_latency", 32'(lat), 32'd6);
        chk("t2_svalid_cycles", 32'(svc), 32'd5);
        chk("t2_s_wdata", s_wdata, 32'h1234_5678);
        chk("t2_s_wstrb", 32'(s_wstrb), 32'hF);

        run_txn(32'h0B00_0000, 4'h0, 32'h0, 0, 0, 0, 0, 32'h1111_1111, lat, svc, tos, rds);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_svalid_cycles", 32'(svc), 32'd0);
        chk("t3_rdata", rds, 32'h0);

        run_txn(32'h0400_0000, 4'h0, 32'h0, 10, 0, 3, 0, 32'h2222_2222, lat, svc, tos, rds);
        @(negedge clk);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_s_valid", 32'(s_valid), 32'h0);
        chk("t6_rst_m_ready", 32'(m_ready), 32'h0);
        chk("t6_svalid_cycles", 32'(svc), 32'd3);
        step();
        run_txn(32'h0400_0008, 4'h0, 32'h0, 1, 0, 0, 0, 32'h3333_0006, lat, svc, tos, rds);
        chk("t6_after_latency", 32'(lat), 32'd3);
        chk("t6_after_rdata", rds, 32'h3333_0006);

        run_txn(32'h0500_0000, 4'h0, 32'h0, 1000, 0, 0, 0, 32'h4444_4444, lat, svc, tos, rds);
        chk("t4_latency", 32'(lat), 32'd17);
        chk("t4_svalid_cycles", 32'(svc), 32'd16);
        chk("t4_pulse", 32'(tos), 32'd1);
        chk("t4_rdata", rds, 32'hDEAD_BEEF);
`ifdef IOMEM_ERR_CAPTURE_EN
        chk("t4_err_addr", err_addr, 32'h0500_0000);
        chk("t4_err_count", 32'(err_count), 32'd1);
`endif
        run_txn(32'h0600_0000, 4'h0, 32'h0, 1000, 0, 0, 16, 32'h4444_4444, lat, svc, tos, rds);
`ifdef IOMEM_ERR_CAPTURE_EN
        chk("t4b_err_addr", err_addr, 32'h0600_0000);
        chk("t4b_err_count", 32'(err_count), 32'd1);
`endif
        err_clear = 1'b1;
        step();
`ifdef IOMEM_ERR_CAPTURE_EN
        chk("t4c_cleared_count", 32'(err_count), 32'd0);
`endif

        run_txn(32'h0400_0000, 4'h0, 32'h0, T - 1, 0, 0, 0, 32'hCAFE_0005, lat, svc, tos, rds);
        chk("t5_latency", 32'(lat), 32'd17);
        chk("t5_pulse", 32'(tos), 32'd0);
        chk("t5_rdata", rds, 32'hCAFE_0005);

        rand_clr = 1;
        for (int n = 0; n < 60; n++) begin
            hi = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(3, 12));
            a  = {hi, 24'($urandom)};
            case ($urandom_range(0, 3))
                0, 1:    d = $urandom_range(0, 4);
                2:       d = $urandom_range(T - 3, T + 1);
                default: d = 100;
            endcase
            run_txn(a, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom, d,
                    ($urandom_range(0, 1) == 1), 0, 0, $urandom, lat, svc, tos, rds);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/iomem_bus_ctrl.md
Name: iomem_bus_ctrl

Overview:
Sequencing controller between the PicoSoC iomem master port and up to NUM_SLAVES memory-mapped peripherals (gpio, audio, video, sdcard, i2c, flash). It decodes the peripheral slot from addr[31:24] and registers the request toward exactly one slave. It waits for that slave's ready, returns one registered response to the CPU, and terminates hung or unmapped accesses deterministically. It replaces the top-level combinational ready/rdata priority mux with one decoded, timeout-protected transaction path.

Parameters:
- NUM_SLAVES, 8, number of slave slots; slot i is decoded at addr[31:24] == SEL_BASE+i.
- SEL_BASE, 8'h03, addr[31:24] value of slot 0.
- SLAVE_PRESENT, 8'hFF, bit i = slot i populated; an unpopulated slot is treated as unmapped.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; range 1..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- m_valid  in  1  CPU request valid
- m_ready  out  1  one-cycle response strobe to the CPU
- m_wstrb  in  4  byte write strobes; 0 = read
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_rdata  out  32  registered response data
- s_valid  out  NUM_SLAVES  one-hot request to the selected slave
- s_wstrb  out  4  latched strobes, shared by all slaves
- s_addr  out  32  latched address, shared by all slaves
- s_wdata  out  32  latched write data, shared by all slaves
- s_ready  in  NUM_SLAVES  per-slave ready
- s_rdata  in  32*NUM_SLAVES  flat read data; slot i is bits [32i+31:32i]
- busy  out  1  high in ACCESS or RESP
- timeout_pulse  out  1  one-cycle pulse when an access is aborted
- err_addr  out  32  last timed-out address (optional feature)
- err_count  out  8  saturating timeout count (optional feature)
- err_clear  in  1  clears err_addr and err_count (optional feature)

Behaviour:
- Reset values: state IDLE; m_ready, s_valid, busy, timeout_pulse = 0; m_rdata, s_addr, s_wdata, s_wstrb = 0; timeout counter = 0; err_addr, err_count = 0. Reset mid-transaction aborts immediately, and no m_ready is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on an edge with m_valid=1 and m_ready=0:
  - Latch m_addr, m_wdata and m_wstrb into the s_* outputs.
  - Compute idx = m_addr[31:24] - SEL_BASE as 8-bit unsigned. It is a hit when idx < NUM_SLAVES and SLAVE_PRESENT[idx]=1.
  - Hit: go to ACCESS, set s_valid[idx]=1, clear the counter.
  - Miss: go to RESP with m_rdata = 0. Writes to a miss are silently dropped.
- ACCESS:
  - s_valid stays one-hot and stable, and the counter increments each cycle.
  - On an edge where s_ready[idx]=1: capture s_rdata slot idx into m_rdata, clear s_valid, go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: clear s_valid, set m_rdata = TIMEOUT_RDATA, pulse timeout_pulse, go to RESP.
  - If s_ready and timeout occur on the same edge, s_ready wins and there is no pulse.
  - s_ready from non-selected slots is ignored at all times.
- RESP: m_ready=1 for exactly one cycle, then go to IDLE. m_ready is never high in IDLE, so a request still held valid is not double-accepted.
- Latency from the edge m_valid is sampled to the m_ready cycle:
  - Miss: 1 cycle.
  - Hit with a slave ready in the first ACCESS cycle: 2 cycles.
  - Timeout: TIMEOUT_CYCLES+1 cycles.
- m_valid dropping during ACCESS does not abort; the transaction completes normally.
- Reads and writes follow the same path. On writes, m_rdata still carries the captured slave data and the CPU ignores it.
- busy = (state != IDLE).

Optional Feature:
IOMEM_ERR_CAPTURE_EN
- Defined:
  - On each timeout, err_addr is loaded with s_addr.
  - err_count increments and saturates at 255.
  - err_clear=1 zeroes both registers on the next edge. If err_clear and a timeout occur on the same edge, the timeout wins: err_count=1 and err_addr is loaded.
- Undefined: err_addr and err_count are tied to 0, and err_clear is ignored. Ports are present in both builds.

Test Plan:
1. Read 0x0300_0010, slave 0 ready in the first ACCESS cycle with rdata 32'h0000_00A5 -> s_valid=8'h01 for 1 cycle; m_ready 2 cycles after the request; m_rdata=32'h0000_00A5.
2. Write 0x0700_0004, wstrb=4'hF, wdata=32'h1234_5678, slave 4 ready after 5 cycles -> s_valid=8'h10 held for 5 cycles; s_wdata=32'h1234_5678; exactly one m_ready.
3. Read 0x0B00_0000 (idx 8, out of range) and a read with SLAVE_PRESENT=8'hFE at 0x0300_0000 -> no s_valid asserted; m_ready 1 cycle later with m_rdata=0.
4. TIMEOUT_CYCLES=16, read 0x0500_0000 with slave 2 never ready -> s_valid[2] high for 16 cycles; timeout_pulse; m_rdata=32'hDEAD_BEEF; with IOMEM_ERR_CAPTURE_EN, err_addr=32'h0500_0000 and err_count=1.
5. s_ready[idx] asserted on the final timeout cycle -> slave data returned, no timeout_pulse; s_ready on a non-selected slot -> ignored, transaction still waits.
6. Assert reset in the 3rd ACCESS cycle -> next cycle s_valid=0, m_ready=0, busy=0; a following read completes normally.
